// File: rtl/mem_pkg.sv
// Shared types and helpers for the word-addressed RAM controller.
// Holds the FSM state enum, the default bad-read word and address helpers.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } state_t;

  localparam logic [31:0] BAD_DATA_DEF = 32'hDEADBEEF;

  // Byte address to word index; caller keeps the low ADDR_WIDTH bits.
  function automatic logic [31:0] word_idx(
    input logic [31:0] addr
  );
    return addr >> 2;
  endfunction

  // True when every bit above the word index is zero.
  function automatic logic in_range(
    input logic [31:0] addr,
    input int unsigned aw
  );
    return (addr >> (aw + 2)) == 32'd0;
  endfunction

endpackage

// File: rtl/ram_array.sv
// Single-port 32-bit RAM: synchronous write, combinational read, no reset.
// Ports: i_clk, i_we, i_addr (word index), i_wdata, o_rdata.
module ram_array #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  i_clk,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [31:0]           i_wdata,
  output logic [31:0]           o_rdata
);

  logic [31:0] r_mem [0:(1<<ADDR_WIDTH)-1];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/memory_controller.sv
// RAM controller for the core's readReq/writeReq pulse protocol with wait
// states, a preload port and a sticky error flag.
// Ports: clk, reset (async low), readReq, writeReq, ramAddress, ramOut,
// ramIn, readAck, writeAck, loadEn, loadAddress, loadData, busy, error.
module memory_controller
  import mem_pkg::*;
#(
  parameter int          ADDR_WIDTH  = 10,
  parameter int          WAIT_STATES = 2,
  parameter logic [31:0] BAD_DATA    = BAD_DATA_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        readReq,
  input  logic        writeReq,
  input  logic [31:0] ramAddress,
  input  logic [31:0] ramOut,
  output logic [31:0] ramIn,
  output logic        readAck,
  output logic        writeAck,
  input  logic        loadEn,
  input  logic [31:0] loadAddress,
  input  logic [31:0] loadData,
  output logic        busy,
  output logic        error
);

  localparam int CW =
    (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(WAIT_STATES);

  state_t r_state;
  state_t w_state_nxt;

  logic [CW-1:0]         r_cnt;
  logic [ADDR_WIDTH-1:0] r_idx;
  logic                  r_oor;
  logic                  r_wr;
  logic [31:0]           r_wdata;
  logic [31:0]           r_rdata;
  logic                  r_err;

  logic [31:0]           w_req_full;
  logic [31:0]           w_ld_full;
  logic [ADDR_WIDTH-1:0] w_req_idx;
  logic [ADDR_WIDTH-1:0] w_ld_idx;
  logic                  w_req_oor;
  logic                  w_ld_oor;
  logic                  w_any_req;
  logic                  w_idle;
  logic                  w_accept;
  logic                  w_ld_ok;
  logic                  w_done;
  logic                  w_commit;
  logic                  w_err_set;
  logic                  w_ram_we;
  logic [ADDR_WIDTH-1:0] w_ram_addr;
  logic [31:0]           w_ram_wdata;
  logic [31:0]           w_ram_rdata;
  logic                  w_unused;

  assign w_req_full = word_idx(ramAddress);
  assign w_ld_full  = word_idx(loadAddress);
  assign w_req_idx  = w_req_full[ADDR_WIDTH-1:0];
  assign w_ld_idx   = w_ld_full[ADDR_WIDTH-1:0];
  assign w_req_oor  = !in_range(ramAddress, ADDR_WIDTH);
  assign w_ld_oor   = !in_range(loadAddress, ADDR_WIDTH);

  // Bits above the index only matter through the range check.
  assign w_unused = ^{w_req_full[31:ADDR_WIDTH],
                      w_ld_full[31:ADDR_WIDTH]};

  assign w_any_req = readReq | writeReq;
  assign w_idle    = (r_state == IDLE);
  assign w_accept  = w_idle & w_any_req;
  assign w_ld_ok   = loadEn & w_idle & ~w_any_req & ~w_ld_oor;

  // w_done marks the edge that enters ACK.
  assign w_done   = (r_state == WAIT) && (r_cnt == '0);
  assign w_commit = w_done & r_wr & ~r_oor;

  assign w_err_set =
      (w_idle & readReq & writeReq)
    | (~w_idle & w_any_req)
    | (loadEn & (~w_idle | w_any_req | w_ld_oor))
    | (w_done & r_oor);

  // A load can only win in IDLE, a commit only in WAIT, so they never meet.
  assign w_ram_we    = w_commit | w_ld_ok;
  assign w_ram_addr  = w_ld_ok ? w_ld_idx : r_idx;
  assign w_ram_wdata = w_ld_ok ? loadData : r_wdata;

  ram_array #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .i_clk   (clk),
    .i_we    (w_ram_we),
    .i_addr  (w_ram_addr),
    .i_wdata (w_ram_wdata),
    .o_rdata (w_ram_rdata)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: if (w_any_req) w_state_nxt = WAIT;
      WAIT: if (r_cnt == '0) w_state_nxt = ACK;
      ACK:  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt   <= '0;
      r_idx   <= '0;
      r_oor   <= 1'b0;
      r_wr    <= 1'b0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_cnt   <= CNT_LOAD;
        r_idx   <= w_req_idx;
        r_oor   <= w_req_oor;
        r_wr    <= writeReq;
        r_wdata <= ramOut;
      end else if (r_state == WAIT && r_cnt != '0) begin
        r_cnt <= r_cnt - CW'(1);
      end
      if (w_done & ~r_wr) begin
        r_rdata <= r_oor ? BAD_DATA : w_ram_rdata;
      end
      if (w_err_set) begin
        r_err <= 1'b1;
      end
    end
  end

  assign ramIn    = r_rdata;
  assign readAck  = (r_state == ACK) & ~r_wr;
  assign writeAck = (r_state == ACK) & r_wr;
  assign busy     = ~w_idle;
  assign error    = r_err;

endmodule

// File: tb/tb_memory_controller.sv
// Scoreboard bench for memory_controller with default parameters.
// Acks are matched against queued expectations for kind, cycle and data.
module tb_memory_controller;

  localparam int WS = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        readReq;
  logic        writeReq;
  logic [31:0] ramAddress;
  logic [31:0] ramOut;
  logic [31:0] ramIn;
  logic        readAck;
  logic        writeAck;
  logic        loadEn;
  logic [31:0] loadAddress;
  logic [31:0] loadData;
  logic        busy;
  logic        error;

  typedef struct {
    logic        wr;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  memory_controller #(
    .ADDR_WIDTH  (10),
    .WAIT_STATES (WS),
    .BAD_DATA    (32'hDEADBEEF)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .readReq     (readReq),
    .writeReq    (writeReq),
    .ramAddress  (ramAddress),
    .ramOut      (ramOut),
    .ramIn       (ramIn),
    .readAck     (readAck),
    .writeAck    (writeAck),
    .loadEn      (loadEn),
    .loadAddress (loadAddress),
    .loadData    (loadData),
    .busy        (busy),
    .error       (error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (readAck || writeAck) begin
      if (sb.size() == 0) begin
        chk("unexp_ack", {30'b0, readAck, writeAck}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("ack_kind", {30'b0, readAck, writeAck},
            {30'b0, ~e.wr, e.wr});
        chk("ack_cyc", cyc, e.cyc);
        if (!e.wr) chk("rdata", ramIn, e.data);
      end
    end
  end

  task automatic req(
    input  logic        r,
    input  logic        w,
    input  logic [31:0] a,
    input  logic [31:0] d,
    output int          k
  );
    @(posedge clk); #1;
    readReq    = r;
    writeReq   = w;
    ramAddress = a;
    ramOut     = d;
    @(posedge clk); #1;
    k        = cyc;
    readReq  = 1'b0;
    writeReq = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] d);
    int k;
    req(1'b1, 1'b0, a, 32'h0, k);
    sb.push_back('{wr: 1'b0, data: d, cyc: k + WS + 1});
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    int k;
    req(1'b0, 1'b1, a, d, k);
    sb.push_back('{wr: 1'b1, data: d, cyc: k + WS + 1});
  endtask

  task automatic load(input logic [31:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    loadEn      = 1'b1;
    loadAddress = a;
    loadData    = d;
    @(posedge clk); #1;
    loadEn = 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (sb.size() == 0) break;
    end
    chk(tag, sb.size(), 32'd0);
    repeat (3) @(negedge clk);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ramIn"}, ramIn, 32'd0);
    chk({tag, "_flags"},
        {28'b0, readAck, writeAck, busy, error}, 32'd0);
  endtask

  task automatic do_reset(input string tag);
    @(posedge clk); #3;
    reset = 1'b0;
    sb.delete();
    #1;
    chk_zero(tag);
    @(posedge clk); #3;
    reset = 1'b1;
  endtask

  initial begin
    int k;
    reset       = 1'b0;
    readReq     = 1'b0;
    writeReq    = 1'b0;
    ramAddress  = '0;
    ramOut      = '0;
    loadEn      = 1'b0;
    loadAddress = '0;
    loadData    = '0;
    repeat (2) @(negedge clk);
    chk_zero("reset");
    reset = 1'b1;

    load(32'h0, 32'h1);
    rd(32'h0, 32'h1);
    for (int i = 0; i < WS + 2; i++) begin
      @(negedge clk);
      chk("busy_hi", {31'b0, busy}, 32'd1);
    end
    @(negedge clk);
    chk("busy_lo", {31'b0, busy}, 32'd0);
    drain("drain_rd0");
    chk("err_clean", {31'b0, error}, 32'd0);

    wr(32'h40, 32'h12345678);
    drain("drain_wr40");
    chk("ramIn_hold", ramIn, 32'h1);
    rd(32'h40, 32'h12345678);
    drain("drain_rd40");
    rd(32'h43, 32'h12345678);
    drain("drain_rd43");
    chk("err_clean2", {31'b0, error}, 32'd0);

    rd(32'h1000, 32'hDEADBEEF);
    drain("drain_oor_rd");
    chk("err_oor_rd", {31'b0, error}, 32'd1);
    wr(32'h1000, 32'h5);
    drain("drain_oor_wr");
    rd(32'h0, 32'h1);
    drain("drain_alias");

    do_reset("rst1");
    req(1'b1, 1'b1, 32'h8, 32'hA5A5A5A5, k);
    sb.push_back('{wr: 1'b1, data: 32'hA5A5A5A5, cyc: k + WS + 1});
    drain("drain_both");
    chk("err_both", {31'b0, error}, 32'd1);
    rd(32'h8, 32'hA5A5A5A5);
    drain("drain_rd8");

    do_reset("rst2");
    rd(32'h0, 32'h1);
    readReq     = 1'b1;
    ramAddress  = 32'h0;
    loadEn      = 1'b1;
    loadAddress = 32'h0;
    loadData    = 32'h99;
    @(posedge clk); #1;
    readReq = 1'b0;
    loadEn  = 1'b0;
    drain("drain_busyreq");
    chk("err_busyreq", {31'b0, error}, 32'd1);
    rd(32'h0, 32'h1);
    drain("drain_noload");

    do_reset("rst3");
    load(32'h10, 32'h7);
    wr(32'h10, 32'hFFFF0000);
    do_reset("rst_mid");
    repeat (10) @(negedge clk);
    chk("abandon", sb.size(), 32'd0);
    rd(32'h10, 32'h7);
    drain("drain_rd10");
    chk("err_clean3", {31'b0, error}, 32'd0);

    load(32'h1000, 32'hBAD);
    @(negedge clk);
    chk("err_oor_ld", {31'b0, error}, 32'd1);
    rd(32'h0, 32'h1);
    drain("drain_final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
